npc_seq_ctrl: RTL and testbench
===============================

NPC_SEQ_CTRL -- requirements
Module: npc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, 8-bit wait limit used only when NPC_SEQ_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ifu_req  out  1  instruction fetch request, held high while waiting for an instruction.
REQ-006 ifu_addr  out  32  fetch address; always equals pc.
REQ-007 ifu_rvalid  in  1  fetch data valid strobe.
REQ-008 ifu_rdata  in  32  fetched instruction word.
REQ-009 inst  out  32  latched instruction presented to the decoder.
REQ-010 dec_stop  in  1  decoder ebreak indication.
REQ-011 dec_memtoreg  in  1  decoder flag indicating that a memory phase is needed.
REQ-012 lsu_req  out  1  load/store request, held high while in MEM.
REQ-013 lsu_done  in  1  load/store completion strobe.
REQ-014 next_pc  in  32  next PC computed by the datapath.
REQ-015 pc  out  32  current PC register.
REQ-016 rf_wen  out  1  register file write enable, one-cycle pulse.
REQ-017 halt  out  1  simulation stop, sticky.
REQ-018 err  out  1  timeout error flag, sticky.
REQ-019 state  out  3  current FSM state code, for debug.

Function
REQ-020 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
REQ-021 In FETCH, ifu_req SHALL be 1; when ifu_rvalid=1, inst SHALL load ifu_rdata and the next state SHALL be DECODE.
REQ-022 In DECODE, the block SHALL go to HALT if dec_stop=1, and to EXEC otherwise.
REQ-023 In EXEC, the block SHALL go to MEM if dec_memtoreg=1, and to WB otherwise.
REQ-024 In MEM, lsu_req SHALL be 1; lsu_done=1 SHALL move the FSM to WB.
REQ-025 In WB, rf_wen SHALL be 1 for exactly one cycle, pc SHALL load next_pc, and the next state SHALL be FETCH.
REQ-026 HALT SHALL be terminal until rst; halt SHALL be 1 there, and all of ifu_req, lsu_req and rf_wen SHALL be 0.
REQ-027 Minimum instruction latency SHALL be 4 cycles (non-memory instruction with ifu_rvalid in the first FETCH cycle), and 5 cycles with a single-cycle MEM phase.
REQ-028 inst SHALL change only on a FETCH handshake; ifu_rvalid outside FETCH SHALL be ignored.
REQ-029 lsu_done outside MEM SHALL be ignored.
REQ-030 rf_wen SHALL be 0 in every state except WB.
REQ-031 pc SHALL change only in WB or on rst.
REQ-032 No handshake SHALL be accepted in the cycle in which rst=1.

Reset
REQ-033 rst=1 at a clock edge SHALL force: state=FETCH, pc=RESET_PC, inst=0, halt=0, err=0, rf_wen=0, lsu_req=0, and the timeout counter to 0, from any state, including mid-MEM and HALT.
REQ-034 ifu_req SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-035 With macro NPC_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to FETCH or MEM and increment each cycle spent waiting there.
REQ-036 With NPC_SEQ_TIMEOUT_EN defined, the FSM SHALL go to ERR when the counter equals TIMEOUT_CYCLES without a handshake.
REQ-037 ERR SHALL be terminal until rst, with err=1, halt=1, and ifu_req=lsu_req=rf_wen=0.
REQ-038 A handshake arriving in the same cycle that the counter reaches the limit SHALL win, and no error SHALL be raised.
REQ-039 Without NPC_SEQ_TIMEOUT_EN, there SHALL be no counter, ERR SHALL be unreachable, err SHALL be tied 0, and waits SHALL be unbounded.

Verification
REQ-040 Reset, then ifu_rvalid=1 on cycle 1 with ifu_rdata=32'h0010_0093, dec_stop=0, dec_memtoreg=0, next_pc=32'h8000_0004 -> rf_wen pulses on cycle 4, and pc=32'h8000_0004 on cycle 5.
REQ-041 Fetch 32'h0010_0073 with dec_stop=1 in DECODE -> halt=1 from the next cycle; later ifu_rvalid pulses SHALL leave inst and pc unchanged.
REQ-042 dec_memtoreg=1 and lsu_done delayed 3 cycles -> lsu_req is high for 4 cycles, and rf_wen pulses once in the cycle after lsu_done.
REQ-043 rst asserted during MEM with lsu_done=1 in the same cycle -> state=FETCH, pc=32'h8000_0000, rf_wen stays 0.
REQ-044 With NPC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, ifu_rvalid held at 0 -> err=1 and halt=1 after 8 cycles waiting in FETCH.
REQ-045 With NPC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, ifu_rvalid arriving in the limit cycle -> DECODE is entered and err stays 0.

Source files
------------

// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle instruction sequencer FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT/ERR terminals.
// Define NPC_SEQ_TIMEOUT_EN to bound FETCH/MEM waits by TIMEOUT_CYCLES; otherwise waits are unbounded and err is 0.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000
`ifdef NPC_SEQ_TIMEOUT_EN
    ,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    input  logic        dec_stop,
    input  logic        dec_memtoreg,
    output logic        lsu_req,
    input  logic        lsu_done,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        rf_wen,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   fetch_hs;
    logic   mem_hs;
    logic   timeout;

    assign fetch_hs = (state_q == S_FETCH) && ifu_rvalid;
    assign mem_hs   = (state_q == S_MEM) && lsu_done;

`ifdef NPC_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counter holds cycles already waited, so the limit cycle is the TIMEOUT_CYCLES-th wait cycle.
    assign timeout = (wait_cnt == TIMEOUT_CYCLES - 8'd1);
    assign err     = (state_q == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if ((state_q == S_FETCH && !fetch_hs) || (state_q == S_MEM && !mem_hs)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake is tested before the timeout so a same-cycle arrival wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (ifu_rvalid)   state_d = S_DECODE;
                else if (timeout) state_d = S_ERR;
            end
            S_DECODE: state_d = dec_stop ? S_HALT : S_EXEC;
            S_EXEC:   state_d = dec_memtoreg ? S_MEM : S_WB;
            S_MEM: begin
                if (lsu_done)     state_d = S_WB;
                else if (timeout) state_d = S_ERR;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        rf_wen  = 1'b0;
        halt    = 1'b0;
        case (state_q)
            S_FETCH:       ifu_req = 1'b1;
            S_MEM:         lsu_req = 1'b1;
            S_WB:          rf_wen  = 1'b1;
            S_HALT, S_ERR: halt    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= 32'd0;
        end else begin
            if (fetch_hs)        inst <= ifu_rdata;
            if (state_q == S_WB) pc   <= next_pc;
        end
    end

    assign ifu_addr = pc;
    assign state    = state_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed table-driven bench for npc_seq_ctrl plus hand-written reset and wait-limit sequences.
module tb_npc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [31:0] inst;
    logic        dec_stop;
    logic        dec_memtoreg;
    logic        lsu_req;
    logic        lsu_done;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        rf_wen;
    logic        halt;
    logic        err;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef NPC_SEQ_TIMEOUT_EN
    npc_seq_ctrl #(.TIMEOUT_CYCLES(8'd8)) dut (
`else
    npc_seq_ctrl dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .ifu_req      (ifu_req),
        .ifu_addr     (ifu_addr),
        .ifu_rvalid   (ifu_rvalid),
        .ifu_rdata    (ifu_rdata),
        .inst         (inst),
        .dec_stop     (dec_stop),
        .dec_memtoreg (dec_memtoreg),
        .lsu_req      (lsu_req),
        .lsu_done     (lsu_done),
        .next_pc      (next_pc),
        .pc           (pc),
        .rf_wen       (rf_wen),
        .halt         (halt),
        .err          (err),
        .state        (state)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rdata;
        logic        stop;
        logic        m2r;
        logic        done;
        logic [31:0] npc;
        logic [2:0]  e_state;
        logic        e_ifu;
        logic        e_lsu;
        logic        e_wen;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_halt;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rv, input logic [31:0] rdata, input logic stop,
                                input logic m2r, input logic done, input logic [31:0] npc,
                                input logic [2:0] st, input logic ifu, input logic lsu,
                                input logic wen, input logic [31:0] p, input logic [31:0] in,
                                input logic h);
        vec_t v;
        v.rv = rv; v.rdata = rdata; v.stop = stop; v.m2r = m2r; v.done = done; v.npc = npc;
        v.e_state = st; v.e_ifu = ifu; v.e_lsu = lsu; v.e_wen = wen;
        v.e_pc = p; v.e_inst = in; v.e_halt = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ifu_rvalid = 1'b0; ifu_rdata = 32'd0; dec_stop = 1'b0;
        dec_memtoreg = 1'b0; lsu_done = 1'b0; next_pc = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Cycle-by-cycle program: ALU op, load with 3-cycle LSU delay, then ebreak.
        tbl[0]  = mk(1, 32'h0010_0093, 0, 0, 0, 32'h8000_0004, 3'd0, 1, 0, 0, 32'h8000_0000, 32'h0000_0000, 0);
        tbl[1]  = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd1, 0, 0, 0, 32'h8000_0000, 32'h0010_0093, 0);
        tbl[2]  = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd2, 0, 0, 0, 32'h8000_0000, 32'h0010_0093, 0);
        tbl[3]  = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd4, 0, 0, 1, 32'h8000_0000, 32'h0010_0093, 0);
        tbl[4]  = mk(0, 32'h0,          0, 0, 1, 32'h8000_0004, 3'd0, 1, 0, 0, 32'h8000_0004, 32'h0010_0093, 0);
        tbl[5]  = mk(1, 32'h0000_2083, 0, 0, 0, 32'h8000_0004, 3'd0, 1, 0, 0, 32'h8000_0004, 32'h0010_0093, 0);
        tbl[6]  = mk(1, 32'hDEAD_BEEF, 0, 1, 0, 32'h8000_0004, 3'd1, 0, 0, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[7]  = mk(0, 32'h0,          0, 1, 0, 32'h8000_0004, 3'd2, 0, 0, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[8]  = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd3, 0, 1, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[9]  = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd3, 0, 1, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[10] = mk(0, 32'h0,          0, 0, 0, 32'h8000_0004, 3'd3, 0, 1, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[11] = mk(0, 32'h0,          0, 0, 1, 32'h8000_0004, 3'd3, 0, 1, 0, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[12] = mk(1, 32'hCAFE_F00D, 0, 0, 0, 32'h8000_0008, 3'd4, 0, 0, 1, 32'h8000_0004, 32'h0000_2083, 0);
        tbl[13] = mk(1, 32'h0010_0073, 0, 0, 0, 32'h8000_0008, 3'd0, 1, 0, 0, 32'h8000_0008, 32'h0000_2083, 0);
        tbl[14] = mk(0, 32'h0,          1, 0, 0, 32'h8000_0008, 3'd1, 0, 0, 0, 32'h8000_0008, 32'h0010_0073, 0);
        tbl[15] = mk(1, 32'h1111_1111, 0, 1, 1, 32'h0000_0000, 3'd5, 0, 0, 0, 32'h8000_0008, 32'h0010_0073, 1);
        tbl[16] = mk(1, 32'h2222_2222, 0, 0, 1, 32'h0000_0000, 3'd5, 0, 0, 0, 32'h8000_0008, 32'h0010_0073, 1);
        tbl[17] = mk(0, 32'h0,          0, 0, 0, 32'h0000_0000, 3'd5, 0, 0, 0, 32'h8000_0008, 32'h0010_0073, 1);

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state",   {29'd0, state}, 32'd0);
        chk("reset_pc",      pc,             32'h8000_0000);
        chk("reset_ifu_addr", ifu_addr,      32'h8000_0000);
        chk("reset_inst",    inst,           32'd0);
        chk("reset_ifu_req", {31'd0, ifu_req}, 32'd1);
        chk("reset_flags",   {28'd0, lsu_req, rf_wen, halt, err}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            ifu_rvalid   = tbl[i].rv;
            ifu_rdata    = tbl[i].rdata;
            dec_stop     = tbl[i].stop;
            dec_memtoreg = tbl[i].m2r;
            lsu_done     = tbl[i].done;
            next_pc      = tbl[i].npc;
            #1;
            chk($sformatf("row%0d_state", i),   {29'd0, state},   {29'd0, tbl[i].e_state});
            chk($sformatf("row%0d_ifu_req", i), {31'd0, ifu_req}, {31'd0, tbl[i].e_ifu});
            chk($sformatf("row%0d_lsu_req", i), {31'd0, lsu_req}, {31'd0, tbl[i].e_lsu});
            chk($sformatf("row%0d_rf_wen", i),  {31'd0, rf_wen},  {31'd0, tbl[i].e_wen});
            chk($sformatf("row%0d_pc", i),      pc,               tbl[i].e_pc);
            chk($sformatf("row%0d_ifu_addr", i), ifu_addr,        tbl[i].e_pc);
            chk($sformatf("row%0d_inst", i),    inst,             tbl[i].e_inst);
            chk($sformatf("row%0d_halt", i),    {31'd0, halt},    {31'd0, tbl[i].e_halt});
            chk($sformatf("row%0d_err", i),     {31'd0, err},     32'd0);
            @(negedge clk);
        end

        // Reset out of HALT with a fetch strobe present: the strobe must not be taken.
        rst = 1'b1; ifu_rvalid = 1'b1; ifu_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = 32'd0;
        #1;
        chk("halt_rst_state", {29'd0, state}, 32'd0);
        chk("halt_rst_halt",  {31'd0, halt},  32'd0);
        chk("halt_rst_inst",  inst,           32'd0);
        chk("halt_rst_pc",    pc,             32'h8000_0000);
        chk("halt_rst_ifu",   {31'd0, ifu_req}, 32'd1);

        // Reset while in MEM with lsu_done in the same cycle.
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_2083; next_pc = 32'h8000_0004;
        @(negedge clk);
        ifu_rvalid = 1'b0; dec_memtoreg = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("memrst_in_mem", {29'd0, state}, 32'd3);
        rst = 1'b1; lsu_done = 1'b1;
        @(negedge clk);
        rst = 1'b0; lsu_done = 1'b0; dec_memtoreg = 1'b0;
        #1;
        chk("memrst_state",  {29'd0, state},   32'd0);
        chk("memrst_pc",     pc,               32'h8000_0000);
        chk("memrst_inst",   inst,             32'd0);
        chk("memrst_rf_wen", {31'd0, rf_wen},  32'd0);
        chk("memrst_lsu",    {31'd0, lsu_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("memrst_rf_wen2", {31'd0, rf_wen}, 32'd0);
        chk("memrst_pc2",     pc,              32'h8000_0000);

`ifdef NPC_SEQ_TIMEOUT_EN
        do_reset();
        repeat (7) @(negedge clk);
        #1;
        chk("to_wait8_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        #1;
        chk("to_err_state", {29'd0, state},   32'd6);
        chk("to_err_err",   {31'd0, err},     32'd1);
        chk("to_err_halt",  {31'd0, halt},    32'd1);
        chk("to_err_ifu",   {31'd0, ifu_req}, 32'd0);
        ifu_rvalid = 1'b1;
        @(negedge clk);
        #1;
        chk("to_err_sticky", {29'd0, state}, 32'd6);

        do_reset();
        repeat (7) @(negedge clk);
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0010_0093;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        #1;
        chk("to_race_state", {29'd0, state}, 32'd1);
        chk("to_race_err",   {31'd0, err},   32'd0);
        chk("to_race_inst",  inst,           32'h0010_0093);
`else
        do_reset();
        repeat (300) @(negedge clk);
        #1;
        chk("nowait_limit_state", {29'd0, state},   32'd0);
        chk("nowait_limit_err",   {31'd0, err},     32'd0);
        chk("nowait_limit_ifu",   {31'd0, ifu_req}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
